// File: rtl/ksa_8.sv
// rtl/ksa_8.sv - registered Kogge-Stone prefix adder with carry-in/out; optional OVF via KSA_OVERFLOW_EN
module ksa_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
`ifdef KSA_OVERFLOW_EN
  ,
  output logic             OVF
`endif
);

  localparam int STAGES = $clog2(WIDTH);

  // Group generate/propagate after each prefix stage; index 0 is the bitwise pre-processing.
  logic [STAGES:0][WIDTH-1:0] g_st;
  logic [STAGES:0][WIDTH-1:0] p_st;
  logic [WIDTH-1:0]           p_bit;
  logic [WIDTH-1:0]           c_vec;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;

  // Bitwise propagate/generate; carry-in folds into bit 0 so it flows through the tree like any generate.
  assign p_bit = A ^ B;

  genvar i, k;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_pre
      if (i == 0) begin : g_fold
        assign g_st[0][i] = (A[i] & B[i]) | (p_bit[i] & CIN);
      end else begin : g_plain
        assign g_st[0][i] = A[i] & B[i];
      end
      assign p_st[0][i] = p_bit[i];
    end

    for (k = 0; k < STAGES; k++) begin : g_stage
      localparam int D = 1 << k;
      for (i = 0; i < WIDTH; i++) begin : g_cell
        if (i >= D) begin : g_black
          assign g_st[k+1][i] = g_st[k][i] | (p_st[k][i] & g_st[k][i-D]);
          assign p_st[k+1][i] = p_st[k][i] & p_st[k][i-D];
        end else begin : g_pass
          assign g_st[k+1][i] = g_st[k][i];
          assign p_st[k+1][i] = p_st[k][i];
        end
      end
    end
  endgenerate

  // Carry into bit i is the final group generate of bits [i-1:0]; bit 0 sees CIN directly.
  assign c_vec   = {g_st[STAGES][WIDTH-2:0], CIN};
  assign sum_d   = p_bit ^ c_vec;
  assign carry_d = g_st[STAGES][WIDTH-1];

  // Result register: one cycle of latency, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign SUM   = sum_q;
  assign CARRY = carry_q;

`ifdef KSA_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_d = c_vec[WIDTH-1] ^ carry_d;

  // Overflow flag registered alongside SUM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_ksa_8.sv
// tb/tb_ksa_8.sv - scoreboard testbench for ksa_8 against an arithmetic reference model
module tb_ksa_8;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic [W-1:0] sum_out;
  logic         carry_out;
`ifdef KSA_OVERFLOW_EN
  logic         ovf_out;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
  } exp_t;

  exp_t exp_q[$];

  ksa_8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a_in),
    .B     (b_in),
    .CIN   (cin_in),
    .SUM   (sum_out),
    .CARRY (carry_out)
`ifdef KSA_OVERFLOW_EN
    ,
    .OVF   (ovf_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition; signed overflow from operand/result sign bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t e;
    int unsigned total;
    total = int'(a) + int'(b) + int'(ci);
    e.s  = W'(total % (1 << W));
    e.c  = (total >= (1 << W));
    e.o  = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    e.a  = a;
    e.b  = b;
    e.ci = ci;
    return e;
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin_in = ci;
    exp_q.push_back(model(a, b, ci));
  endtask

  // Expected values for directed boundaries are also written out as constants.
  task automatic apply_const(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                             input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin_in = ci;
    e = '{s: s, c: c, o: o, a: a, b: b, ci: ci};
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (sum_out !== '0 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL %s: got sum=%h carry=%b, want sum=00 carry=0", name, sum_out, carry_out);
    end
`ifdef KSA_OVERFLOW_EN
    checks++;
    if (ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL %s ovf: got %b, want 0", name, ovf_out);
    end
`endif
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d results outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: the DUT presents a new result after every edge; pop one expectation per edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sum_out !== e.s || carry_out !== e.c) begin
          errors++;
          $display("FAIL sum %h+%h+%b: got carry=%b sum=%h, want carry=%b sum=%h",
                   e.a, e.b, e.ci, carry_out, sum_out, e.c, e.s);
        end
`ifdef KSA_OVERFLOW_EN
        checks++;
        if (ovf_out !== e.o) begin
          errors++;
          $display("FAIL ovf %h+%h+%b: got %b, want %b", e.a, e.b, e.ci, ovf_out, e.o);
        end
`endif
      end
    end
  end

  initial begin : stimulus
    rst_n  = 1'b0;
    a_in   = 8'hFF;
    b_in   = 8'hFF;
    cin_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset_hold");
    end
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    apply_const(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0);
    apply_const(8'h77, 8'h55, 1'b0, 8'hCC, 1'b0, 1'b1);
    apply_const(8'h0C, 8'h14, 1'b0, 8'h20, 1'b0, 1'b0);
    apply_const(8'h56, 8'h61, 1'b0, 8'hB7, 1'b0, 1'b1);
    apply_const(8'hEA, 8'hD5, 1'b0, 8'hBF, 1'b1, 1'b0);
    apply_const(8'h85, 8'hFF, 1'b0, 8'h84, 1'b1, 1'b0);
    apply_const(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    apply_const(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    apply_const(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    apply_const(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    apply_const(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    apply_const(8'hEA, 8'hD5, 1'b1, 8'hC0, 1'b1, 1'b0);
    drain("directed");

    // Asynchronous reset between edges clears a nonzero result immediately.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    check_idle("async_reset_held");
    rst_n = 1'b1;

    // Sweep every B and both CIN values for a few edge-case A operands.
    for (int ai = 0; ai < 4; ai++) begin
      logic [W-1:0] av;
      logic [3:0][W-1:0] alist;
      alist = {8'hFF, 8'h80, 8'h7F, 8'h00};
      av = alist[ai];
      for (int bi = 0; bi < 256; bi++) begin
        apply(av, W'(bi), 1'b0);
        apply(av, W'(bi), 1'b1);
      end
    end

    // Random back-to-back vectors.
    for (int n = 0; n < 20000; n++) begin
      apply(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
